// File: rtl/ksa_pkg.sv
// Shared definitions for the Kogge-Stone adder/subtractor family:
// generate/propagate pair type and the associative prefix operator.
package ksa_pkg;

  localparam int N_DEF     = 16;
  localparam int LOG2N_DEF = $clog2(N_DEF);

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // (G,P) o (G',P') = (G | P&G', P&P'); hi is the more significant span.
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/ksa_prefix_net.sv
// Combinational log2(N)-level Kogge-Stone carry network with carry-in.
// Shared between the adder and the subtractor.
module ksa_prefix_net
  import ksa_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] g,
  input  logic [N-1:0] p,
  input  logic         c0,
  output logic [N:0]   c
);

  localparam int LOG2N = $clog2(N);

  logic [N:0] gv;
  logic [N:0] pv;
  logic [N:0] gn;
  logic [N:0] pn;
  gp_t        node;

  // Position 0 carries c0 as a generate with propagate 0; position j+1 is bit j.
  always_comb begin
    gv   = {g, c0};
    pv   = {p, 1'b0};
    gn   = gv;
    pn   = pv;
    node = '0;
    for (int l = 0; l < LOG2N; l++) begin
      for (int j = N; j >= (1 << l); j--) begin
        node  = gp_combine(gp_t'{gv[j], pv[j]}, gp_t'{gv[j-(1<<l)], pv[j-(1<<l)]});
        gn[j] = node.g;
        pn[j] = node.p;
      end
      gv = gn;
      pv = pn;
    end
    c[N-1:0] = gv[N-1:0];
    // After log2(N) levels the top span reaches bit 0 but not the carry-in slot.
    c[N] = gv[N] | (pv[N] & c0);
  end

endmodule

// File: rtl/ksa_sub_pipe.sv
// Three-stage pipelined Kogge-Stone subtractor (a - b - bin) with
// valid/ready flow control; each stage refills as soon as it is drained.
module ksa_sub_pipe
  import ksa_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic         vld_p0;
  logic         vld_p1;
  logic         vld_p2;
  logic         adv_p0;
  logic         adv_p1;
  logic         adv_p2;
  logic [N-1:0] b_inv;
  logic [N-1:0] g_p0;
  logic [N-1:0] p_p0;
  logic         c0_p0;
  logic [N:0]   carry_c;
  logic [N:0]   carry_p1;
  logic [N-1:0] p_p1;

  assign b_inv = ~b;

  // Ready chain runs back from the consumer; a stage loads when empty or draining.
  assign adv_p2    = ~vld_p2 | out_ready;
  assign adv_p1    = ~vld_p1 | adv_p2;
  assign adv_p0    = ~vld_p0 | adv_p1;
  assign in_ready  = adv_p0;
  assign out_valid = vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p0) vld_p0 <= in_valid;
      if (adv_p1) vld_p1 <= vld_p0;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // ---- stage 1: generate/propagate of a + ~b + ~bin ----
  always_ff @(posedge clk) begin
    if (adv_p0 && in_valid) begin
      g_p0  <= a & b_inv;
      p_p0  <= a ^ b_inv;
      c0_p0 <= ~bin;
    end
  end

  ksa_prefix_net #(
    .N (N)
  ) u_prefix (
    .g  (g_p0),
    .p  (p_p0),
    .c0 (c0_p0),
    .c  (carry_c)
  );

  // ---- stage 2: prefix carries ----
  always_ff @(posedge clk) begin
    if (adv_p1 && vld_p0) begin
      carry_p1 <= carry_c;
      p_p1     <= p_p0;
    end
  end

  // ---- stage 3: sum and borrow, driven straight from flops ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff <= '0;
      bout <= 1'b0;
    end else if (adv_p2 && vld_p1) begin
      diff <= p_p1 ^ carry_p1[N-1:0];
      bout <= ~carry_p1[N];
    end
  end

endmodule

// File: tb/tb_ksa_sub_pipe.sv
// Randomized bench for ksa_sub_pipe against a queue-based arithmetic model.
module tb_ksa_sub_pipe;

  localparam int N = 16;

  typedef struct packed {
    logic [N-1:0] d;
    logic         bo;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] diff;
  logic         bout;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int pushed = 0;
  int popped = 0;

  res_t exp_q[$];
  int   acc_q[$];
  logic exp_ov;
  logic prev_hold = 1'b0;
  res_t prev_out;
  res_t cur_out;

  ksa_sub_pipe #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic res_t ref_sub(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi);
    res_t r;
    r.d  = x - y - {{(N-1){1'b0}}, bi};
    r.bo = (int'(x) < int'(y) + int'(bi));
    return r;
  endfunction

  task automatic check(input string nm, input longint unsigned act, input longint unsigned expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // Single compare process: judges every cycle after inputs have settled.
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      prev_hold = 1'b0;
      check("reset_out_valid", 64'(out_valid), 64'(0));
      check("reset_outputs", 64'({diff, bout}), 64'(0));
    end else begin
      exp_ov = 1'b0;
      // handshake seen with edge count E -> result offered once edge count reaches E+3
      if (acc_q.size() > 0) exp_ov = (edge_n >= acc_q[0] + 3);
      check("in_ready", 64'(in_ready), 64'((exp_q.size() < 3) || out_ready));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      cur_out = {diff, bout};
      if (out_valid && exp_q.size() > 0) begin
        check("diff", 64'(diff), 64'(exp_q[0].d));
        check("bout", 64'(bout), 64'(exp_q[0].bo));
      end
      if (prev_hold) check("hold_stable", 64'(cur_out), 64'(prev_out));
      prev_hold = out_valid && !out_ready;
      prev_out  = cur_out;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
        popped++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_sub(a, b, bin));
        acc_q.push_back(edge_n);
        pushed++;
      end
    end
  end

  task automatic drive(input logic iv, input logic [N-1:0] x, input logic [N-1:0] y,
                       input logic bi, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    a         = x;
    b         = y;
    bin       = bi;
    out_ready = ordy;
  endtask

  task automatic drive_rand(input logic iv, input logic ordy);
    drive(iv, 16'($urandom), 16'($urandom), 1'($urandom), ordy);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      #3;
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic directed(input logic [N-1:0] x, input logic [N-1:0] y, input logic bi,
                          input logic [N-1:0] ed, input logic eb);
    drive(1'b1, x, y, bi, 1'b1);
    #1 check("dir_in_ready", 64'(in_ready), 64'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #1 check("dir_not_early", 64'(out_valid), 64'(0));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    #1 check("dir_latency3", 64'(out_valid), 64'(1));
    check("dir_diff", 64'(diff), 64'(ed));
    check("dir_bout", 64'(bout), 64'(eb));
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int acc;
    int budget;

    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_diff", 64'(diff), 64'(0));
    check("rst_bout", 64'(bout), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_release_in_ready", 64'(in_ready), 64'(1));

    // Hand-computed anchors for the model.
    check("model_basic", 64'(ref_sub(16'h1234, 16'h0234, 1'b0)), 64'({16'h1000, 1'b0}));
    check("model_borrow", 64'(ref_sub(16'h0000, 16'h0001, 1'b0)), 64'({16'hFFFF, 1'b1}));
    check("model_eq_bin", 64'(ref_sub(16'h0005, 16'h0005, 1'b1)), 64'({16'hFFFF, 1'b1}));
    check("model_top", 64'(ref_sub(16'hFFFF, 16'h0000, 1'b0)), 64'({16'hFFFF, 1'b0}));

    directed(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0);
    directed(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1);
    directed(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1);
    directed(16'hA5C3, 16'hA5C3, 1'b0, 16'h0000, 1'b0);
    directed(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1);
    directed(16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0);

    // Full-rate streaming.
    base = popped;
    for (int i = 0; i < 100; i++) drive_rand(1'b1, 1'b1);
    drain();
    check("stream_count", 64'(popped - base), 64'(100));

    // Back-pressure with the pipe filling up.
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1, 1'b0);
      #1 if (in_ready) acc++;
    end
    check("bp_accepts", 64'(acc), 64'(3));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    base = popped;
    drive_rand(1'b1, 1'b1);
    #1 check("bp_release_ready", 64'(in_ready), 64'(1));
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drain();
    check("bp_no_loss", 64'(popped - base), 64'(4));

    // Random valid/ready at 50% duty.
    base = pushed;
    budget = 0;
    while (pushed - base < 1000 && budget < 20000) begin
      drive_rand(1'(($urandom % 2)), 1'(($urandom % 2)));
      budget++;
    end
    check("rand_budget", 64'(pushed - base >= 1000), 64'(1));
    drain();

    // Reset with two beats in flight.
    drive(1'b1, 16'h0100, 16'h0001, 1'b0, 1'b0);
    drive(1'b1, 16'h0200, 16'h0002, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #1 check("pre_reset_valid", 64'(out_valid), 64'(1));
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_outputs", 64'({diff, bout}), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    directed(16'h0003, 16'h0007, 1'b0, 16'hFFFC, 1'b1);

    drive(1'b0, '0, '0, 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
